// File: rtl/clock_pkg.sv
// Shared constants for the HH:MM:SS timekeeper: segment patterns {g,f,e,d,c,b,a}
// for one lit segment per '1', and the BCD digit limits of the 24-hour counter chain.
package clock_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] UNITS_MAX           = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX        = 4'd5;
  localparam logic [3:0] MIN_TENS_MAX        = 4'd5;
  localparam logic [3:0] HOUR_MAX_TENS       = 4'd2;
  localparam logic [3:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to 7-segment pattern, purely combinational (zero latency, no flow control).
// Codes 10-15 blank; SEG_ACTIVE_LOW inverts the pattern for common-anode parts.
module seven_seg_decoder
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  logic [6:0] seg_raw;

  always_comb begin
    seg_raw = SEG_BLANK;
    case (bcd)
      4'd0:    seg_raw = SEG_0;
      4'd1:    seg_raw = SEG_1;
      4'd2:    seg_raw = SEG_2;
      4'd3:    seg_raw = SEG_3;
      4'd4:    seg_raw = SEG_4;
      4'd5:    seg_raw = SEG_5;
      4'd6:    seg_raw = SEG_6;
      4'd7:    seg_raw = SEG_7;
      4'd8:    seg_raw = SEG_8;
      4'd9:    seg_raw = SEG_9;
      default: seg_raw = SEG_BLANK;
    endcase
  end

  assign seg = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;

endmodule

// File: rtl/digital_clock.sv
// 24-hour BCD timekeeper, +1 s per clk_1hz edge; displays are a same-cycle decode of the counters.
// No flow control: every edge with reset high advances the time.
module digital_clock
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk_1hz,
  input  logic       reset,
  output logic [6:0] sec_units_display,
  output logic [6:0] sec_tens_display,
  output logic [6:0] min_units_display,
  output logic [6:0] min_tens_display,
  output logic [6:0] hour_units_display,
  output logic [6:0] hour_tens_display
);

  logic [3:0] su, st, mu, mt, hu, ht;
  logic       sec_carry, min_carry;

  // Carries fire only from the legal terminal count, so a corrupted group never ripples.
  always_comb begin
    sec_carry = (su == UNITS_MAX) && (st == SEC_TENS_MAX);
    min_carry = sec_carry && (mu == UNITS_MAX) && (mt == MIN_TENS_MAX);
  end

  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      su <= 4'd0;
      st <= 4'd0;
    end else if ((su > UNITS_MAX) || (st > SEC_TENS_MAX)) begin
      su <= 4'd0;
      st <= 4'd0;
    end else if (su == UNITS_MAX) begin
      su <= 4'd0;
      st <= (st == SEC_TENS_MAX) ? 4'd0 : st + 4'd1;
    end else begin
      su <= su + 4'd1;
    end
  end

  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      mu <= 4'd0;
      mt <= 4'd0;
    end else if (sec_carry) begin
      if ((mu > UNITS_MAX) || (mt > MIN_TENS_MAX)) begin
        mu <= 4'd0;
        mt <= 4'd0;
      end else if (mu == UNITS_MAX) begin
        mu <= 4'd0;
        mt <= (mt == MIN_TENS_MAX) ? 4'd0 : mt + 4'd1;
      end else begin
        mu <= mu + 4'd1;
      end
    end
  end

  // 23 -> 00 and any out-of-range hour share the same clear path.
  always_ff @(posedge clk_1hz or negedge reset) begin
    if (!reset) begin
      hu <= 4'd0;
      ht <= 4'd0;
    end else if (min_carry) begin
      if ((ht > HOUR_MAX_TENS) || (hu > UNITS_MAX) ||
          ((ht == HOUR_MAX_TENS) && (hu >= HOUR_MAX_UNITS_AT_2))) begin
        hu <= 4'd0;
        ht <= 4'd0;
      end else if (hu == UNITS_MAX) begin
        hu <= 4'd0;
        ht <= ht + 4'd1;
      end else begin
        hu <= hu + 4'd1;
      end
    end
  end

  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_su (.bcd(su), .seg(sec_units_display));
  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_st (.bcd(st), .seg(sec_tens_display));
  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_mu (.bcd(mu), .seg(min_units_display));
  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_mt (.bcd(mt), .seg(min_tens_display));
  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_hu (.bcd(hu), .seg(hour_units_display));
  seven_seg_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec_ht (.bcd(ht), .seg(hour_tens_display));

endmodule

// File: tb/tb_digital_clock.sv
// Bench for digital_clock: an active-high and an active-low instance run in lockstep
// against a seconds-of-day reference model.
module tb_digital_clock;

  logic       clk_1hz;
  logic       reset;
  logic [6:0] hi_seg [6];
  logic [6:0] lo_seg [6];

  int t_sec;
  int n_assert;
  int n_fail;

  digital_clock #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clk_1hz            (clk_1hz),
    .reset              (reset),
    .sec_units_display  (hi_seg[0]),
    .sec_tens_display   (hi_seg[1]),
    .min_units_display  (hi_seg[2]),
    .min_tens_display   (hi_seg[3]),
    .hour_units_display (hi_seg[4]),
    .hour_tens_display  (hi_seg[5])
  );

  digital_clock #(.SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clk_1hz            (clk_1hz),
    .reset              (reset),
    .sec_units_display  (lo_seg[0]),
    .sec_tens_display   (lo_seg[1]),
    .min_units_display  (lo_seg[2]),
    .min_tens_display   (lo_seg[3]),
    .hour_units_display (lo_seg[4]),
    .hour_tens_display  (lo_seg[5])
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  function automatic logic [6:0] seg_of(input int digit, input bit active_low);
    logic [6:0] p;
    case (digit)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;  4: p = 7'h66;
      5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;  8: p = 7'h7F;  9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return active_low ? ~p : p;
  endfunction

  function automatic int digit_of(input int tod, input int idx);
    int h, m, s;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
    case (idx)
      0: return s % 10;
      1: return s / 10;
      2: return m % 10;
      3: return m / 10;
      4: return h % 10;
      default: return h / 10;
    endcase
  endfunction

  task automatic check(input string tag, input int idx, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s digit%0d observed=%h expected=%h (model t=%0d)", tag, idx, obs, exp, t_sec);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) begin
      check({tag, "_hi"}, i, hi_seg[i], seg_of(digit_of(t_sec, i), 1'b0));
      check({tag, "_lo"}, i, lo_seg[i], seg_of(digit_of(t_sec, i), 1'b1));
    end
  endtask

  // Reference: one second per rising edge seen with reset released.
  task automatic tick();
    @(posedge clk_1hz);
    if (reset) t_sec = (t_sec + 1) % 86400;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic preload(input int h, input int m, input int s);
    logic [3:0] v0, v1, v2, v3, v4, v5;
    v0 = 4'(s % 10); v1 = 4'(s / 10);
    v2 = 4'(m % 10); v3 = 4'(m / 10);
    v4 = 4'(h % 10); v5 = 4'(h / 10);
    force dut_hi.su = v0; force dut_hi.st = v1; force dut_hi.mu = v2;
    force dut_hi.mt = v3; force dut_hi.hu = v4; force dut_hi.ht = v5;
    force dut_lo.su = v0; force dut_lo.st = v1; force dut_lo.mu = v2;
    force dut_lo.mt = v3; force dut_lo.hu = v4; force dut_lo.ht = v5;
    #1;
    release dut_hi.su; release dut_hi.st; release dut_hi.mu;
    release dut_hi.mt; release dut_hi.hu; release dut_hi.ht;
    release dut_lo.su; release dut_lo.st; release dut_lo.mu;
    release dut_lo.mt; release dut_lo.hu; release dut_lo.ht;
    t_sec = h * 3600 + m * 60 + s;
    #1;
    check_all("preload");
  endtask

  task automatic async_reset_pulse(input string tag);
    #($urandom_range(1, 3));
    reset = 1'b0;
    t_sec = 0;
    #1;
    check_all({tag, "_assert"});
    tick();
    check_all({tag, "_held"});
    reset = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    t_sec    = 0;
    reset    = 1'b0;

    // Reset held across two edges, then released.
    #1;
    check_all("rst_init");
    ticks(2);
    check_all("rst_hold");
    reset = 1'b1;
    check_all("released");
    tick();
    check_all("first_edge");
    ticks(9);
    check_all("ten_edges");
    ticks(90);
    check_all("hundred_edges");

    // Asynchronous reset at 00:00:37.
    async_reset_pulse("pre37");
    ticks(37);
    check_all("at_37");
    async_reset_pulse("mid37");
    tick();
    check_all("resume");

    // Rollover boundaries.
    preload(23, 59, 59);
    tick();
    check_all("day_wrap");
    preload(9, 59, 59);
    tick();
    check_all("to_ten_hours");
    preload(19, 59, 59);
    tick();
    check_all("to_twenty");
    preload(22, 59, 58);
    ticks(3);
    check_all("to_23");

    // Random preloads, run lengths and mid-count resets.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 2) == 0)
        preload($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      ticks($urandom_range(1, 150));
      check_all("rand_run");
      if ($urandom_range(0, 3) == 0) async_reset_pulse("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
